wb_initiator: RTL and testbench

- Wishbone B4 classic-cycle master that turns single-word requests from a valid/ready command port into one bus cycle each.
- Returns read data and status on a valid/ready response port.
- Acts as the initiator counterpart to the user-area Wishbone slave port, for bench traffic generation and for on-chip engines that drive a Wishbone slave.
- No pipelining; one outstanding transaction at a time.

---
 rtl/wb_initiator.sv | 183 ++++++++++++++++++
 tb/tb_wb_initiator.sv | 301 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/wb_initiator.sv
// wb_initiator: Wishbone B4 classic-cycle master. Each request accepted on the
// valid/ready command port becomes one bus cycle; the outcome is returned on
// the valid/ready response port. One transaction outstanding at a time.
// Optional bus watchdog: define WB_INIT_TIMEOUT_EN to terminate a cycle with
// an error after TIMEOUT clocks without ack/err.
module wb_initiator #(
  parameter int unsigned ADDR_W  = 32,
  parameter int unsigned DATA_W  = 32,
  parameter int unsigned TIMEOUT = 255
) (
  input  logic                  wb_clk_i,
  input  logic                  wb_rst_i,
  input  logic                  req_valid,
  output logic                  req_ready,
  input  logic                  req_we,
  input  logic [ADDR_W-1:0]     req_adr,
  input  logic [DATA_W-1:0]     req_dat,
  input  logic [DATA_W/8-1:0]   req_sel,
  output logic                  rsp_valid,
  input  logic                  rsp_ready,
  output logic [DATA_W-1:0]     rsp_dat,
  output logic                  rsp_err,
  output logic                  wbm_cyc_o,
  output logic                  wbm_stb_o,
  output logic                  wbm_we_o,
  output logic [DATA_W/8-1:0]   wbm_sel_o,
  output logic [ADDR_W-1:0]     wbm_adr_o,
  output logic [DATA_W-1:0]     wbm_dat_o,
  input  logic                  wbm_ack_i,
  input  logic                  wbm_err_i,
  input  logic [DATA_W-1:0]     wbm_dat_i
);

  localparam int unsigned SEL_W = DATA_W / 8;

  // Reject unusable configurations at elaboration.
  if ((DATA_W % 8) != 0 || TIMEOUT < 1 || TIMEOUT > 65535) begin : g_bad_param
    $error("wb_initiator: DATA_W must be a multiple of 8 and TIMEOUT in 1..65535");
  end

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUS  = 2'd1,
    RESP = 2'd2
  } state_t;

  state_t              state_q, state_d;
  logic                req_ready_d;
  logic                rsp_valid_d;
  logic [DATA_W-1:0]   rsp_dat_d;
  logic                rsp_err_d;
  logic                cyc_d;
  logic                stb_d;
  logic                we_d;
  logic [SEL_W-1:0]    sel_d;
  logic [ADDR_W-1:0]   adr_d;
  logic [DATA_W-1:0]   dat_d;

`ifdef WB_INIT_TIMEOUT_EN
  localparam logic [15:0] TO_LIM = 16'(TIMEOUT);
  logic [15:0] cnt_q, cnt_d;
`endif

  // Next-state and next-output computation; every register holds by default.
  always_comb begin
    state_d     = state_q;
    req_ready_d = req_ready;
    rsp_valid_d = rsp_valid;
    rsp_dat_d   = rsp_dat;
    rsp_err_d   = rsp_err;
    cyc_d       = wbm_cyc_o;
    stb_d       = wbm_stb_o;
    we_d        = wbm_we_o;
    sel_d       = wbm_sel_o;
    adr_d       = wbm_adr_o;
    dat_d       = wbm_dat_o;
`ifdef WB_INIT_TIMEOUT_EN
    cnt_d       = cnt_q;
`endif
    case (state_q)
      IDLE: begin
        req_ready_d = 1'b1;
        if (req_valid && req_ready) begin
          req_ready_d = 1'b0;
          cyc_d       = 1'b1;
          stb_d       = 1'b1;
          we_d        = req_we;
          sel_d       = req_sel;
          adr_d       = req_adr;
          dat_d       = req_dat;
          state_d     = BUS;
`ifdef WB_INIT_TIMEOUT_EN
          cnt_d       = '0;
`endif
        end
      end
      BUS: begin
        if (wbm_err_i) begin
          cyc_d       = 1'b0;
          stb_d       = 1'b0;
          rsp_valid_d = 1'b1;
          rsp_err_d   = 1'b1;
          rsp_dat_d   = '0;
          state_d     = RESP;
        end else if (wbm_ack_i) begin
          cyc_d       = 1'b0;
          stb_d       = 1'b0;
          rsp_valid_d = 1'b1;
          rsp_err_d   = 1'b0;
          rsp_dat_d   = wbm_we_o ? '0 : wbm_dat_i;
          state_d     = RESP;
        end
`ifdef WB_INIT_TIMEOUT_EN
        // The edge that would bring the count to TIMEOUT ends the cycle, so
        // cyc/stb stay high for exactly TIMEOUT clocks.
        else if (cnt_q + 16'd1 == TO_LIM) begin
          cyc_d       = 1'b0;
          stb_d       = 1'b0;
          rsp_valid_d = 1'b1;
          rsp_err_d   = 1'b1;
          rsp_dat_d   = '0;
          state_d     = RESP;
        end else begin
          cnt_d       = cnt_q + 16'd1;
        end
`endif
      end
      RESP: begin
        if (rsp_ready) begin
          rsp_valid_d = 1'b0;
          rsp_dat_d   = '0;
          rsp_err_d   = 1'b0;
          req_ready_d = 1'b1;
          state_d     = IDLE;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // State and output registers; reset clears everything including the bus.
  always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
    if (wb_rst_i) begin
      state_q   <= IDLE;
      req_ready <= 1'b0;
      rsp_valid <= 1'b0;
      rsp_dat   <= '0;
      rsp_err   <= 1'b0;
      wbm_cyc_o <= 1'b0;
      wbm_stb_o <= 1'b0;
      wbm_we_o  <= 1'b0;
      wbm_sel_o <= '0;
      wbm_adr_o <= '0;
      wbm_dat_o <= '0;
    end else begin
      state_q   <= state_d;
      req_ready <= req_ready_d;
      rsp_valid <= rsp_valid_d;
      rsp_dat   <= rsp_dat_d;
      rsp_err   <= rsp_err_d;
      wbm_cyc_o <= cyc_d;
      wbm_stb_o <= stb_d;
      wbm_we_o  <= we_d;
      wbm_sel_o <= sel_d;
      wbm_adr_o <= adr_d;
      wbm_dat_o <= dat_d;
    end
  end

`ifdef WB_INIT_TIMEOUT_EN
  // Watchdog count of BUS clocks without a slave response.
  always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
    if (wb_rst_i) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end
`endif

endmodule

// File: tb/tb_wb_initiator.sv
// tb_wb_initiator: directed, table-driven bench for wb_initiator plus
// hand-written sequences for backpressure, mid-cycle reset, the watchdog
// and back-to-back throughput.
module tb_wb_initiator;

  logic        wb_clk_i = 1'b0;
  logic        wb_rst_i;
  logic        req_valid;
  logic        req_ready;
  logic        req_we;
  logic [31:0] req_adr;
  logic [31:0] req_dat;
  logic [3:0]  req_sel;
  logic        rsp_valid;
  logic        rsp_ready;
  logic [31:0] rsp_dat;
  logic        rsp_err;
  logic        wbm_cyc_o;
  logic        wbm_stb_o;
  logic        wbm_we_o;
  logic [3:0]  wbm_sel_o;
  logic [31:0] wbm_adr_o;
  logic [31:0] wbm_dat_o;
  logic        wbm_ack_i;
  logic        wbm_err_i;
  logic [31:0] wbm_dat_i;

  // Slave: either driven by hand or a zero-wait model whose read data is a
  // fixed function of the address.
  logic        auto_mode = 1'b0;
  logic        ack_man   = 1'b0;
  logic        err_man   = 1'b0;
  logic [31:0] dat_man   = '0;

  assign wbm_ack_i = auto_mode ? (wbm_cyc_o & wbm_stb_o) : ack_man;
  assign wbm_err_i = auto_mode ? 1'b0 : err_man;
  assign wbm_dat_i = auto_mode ? (32'hC0DE_0000 | {26'd0, wbm_adr_o[7:2]}) : dat_man;

  wb_initiator #(.ADDR_W(32), .DATA_W(32), .TIMEOUT(8)) dut (
    .wb_clk_i (wb_clk_i),
    .wb_rst_i (wb_rst_i),
    .req_valid(req_valid),
    .req_ready(req_ready),
    .req_we   (req_we),
    .req_adr  (req_adr),
    .req_dat  (req_dat),
    .req_sel  (req_sel),
    .rsp_valid(rsp_valid),
    .rsp_ready(rsp_ready),
    .rsp_dat  (rsp_dat),
    .rsp_err  (rsp_err),
    .wbm_cyc_o(wbm_cyc_o),
    .wbm_stb_o(wbm_stb_o),
    .wbm_we_o (wbm_we_o),
    .wbm_sel_o(wbm_sel_o),
    .wbm_adr_o(wbm_adr_o),
    .wbm_dat_o(wbm_dat_o),
    .wbm_ack_i(wbm_ack_i),
    .wbm_err_i(wbm_err_i),
    .wbm_dat_i(wbm_dat_i)
  );

  always #5 wb_clk_i = ~wb_clk_i;

  int cyc_n = 0;
  always @(posedge wb_clk_i) cyc_n <= cyc_n + 1;

  // Response and write-capture monitors for the back-to-back run.
  logic        mon_en = 1'b0;
  logic [31:0] q_dat[$];
  logic        q_err[$];
  int          q_cyc[$];
  logic [31:0] wlog[16];

  always @(negedge wb_clk_i) begin
    if (mon_en && rsp_valid && rsp_ready) begin
      q_dat.push_back(rsp_dat);
      q_err.push_back(rsp_err);
      q_cyc.push_back(cyc_n);
    end
    if (auto_mode && wbm_cyc_o && wbm_stb_o && wbm_we_o)
      wlog[wbm_adr_o[5:2]] <= wbm_dat_o;
  end

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge wb_clk_i);
    #1;
  endtask

  // Present one request while req_ready is high; returns after the accept edge.
  task automatic issue(input logic we, input logic [31:0] adr, input logic [31:0] dat,
                       input logic [3:0] sel);
    check("req_ready_before", {63'd0, req_ready}, 64'd1);
    req_we = we; req_adr = adr; req_dat = dat; req_sel = sel; req_valid = 1'b1;
    tick();
    req_valid = 1'b0;
    check("accept_cyc", {63'd0, wbm_cyc_o}, 64'd1);
    check("accept_stb", {63'd0, wbm_stb_o}, 64'd1);
    check("accept_we", {63'd0, wbm_we_o}, {63'd0, we});
    check("accept_adr", {32'd0, wbm_adr_o}, {32'd0, adr});
    check("accept_dat", {32'd0, wbm_dat_o}, {32'd0, dat});
    check("accept_sel", {60'd0, wbm_sel_o}, {60'd0, sel});
    check("accept_req_ready", {63'd0, req_ready}, 64'd0);
  endtask

  typedef struct {
    logic        we;
    logic [31:0] adr;
    logic [31:0] dat;
    logic [3:0]  sel;
    int unsigned waits;
    logic        ack;
    logic        err;
    logic [31:0] sdat;
    logic [31:0] exp_dat;
    logic        exp_err;
  } vec_t;

  vec_t vecs[6];

  initial begin
    wb_rst_i  = 1'b1;
    req_valid = 1'b0;
    req_we    = 1'b0;
    req_adr   = '0;
    req_dat   = '0;
    req_sel   = '0;
    rsp_ready = 1'b0;

    //         we    adr            dat            sel   wt ack   err   slave dat      exp dat        exp err
    vecs[0] = '{1'b1, 32'h3000_0004, 32'hDEAD_BEEF, 4'hF, 0, 1'b1, 1'b0, 32'hFFFF_FFFF, 32'h0000_0000, 1'b0};
    vecs[1] = '{1'b0, 32'h3000_0000, 32'h0000_0000, 4'hF, 3, 1'b1, 1'b0, 32'h1234_5678, 32'h1234_5678, 1'b0};
    vecs[2] = '{1'b0, 32'h3000_0008, 32'h1111_2222, 4'hF, 1, 1'b0, 1'b1, 32'hA5A5_A5A5, 32'h0000_0000, 1'b1};
    vecs[3] = '{1'b1, 32'h3000_000C, 32'h5555_AAAA, 4'h0, 2, 1'b1, 1'b0, 32'h7777_7777, 32'h0000_0000, 1'b0};
    vecs[4] = '{1'b0, 32'h0000_0100, 32'h0000_0000, 4'h3, 1, 1'b1, 1'b0, 32'h0BAD_F00D, 32'h0BAD_F00D, 1'b0};
    vecs[5] = '{1'b0, 32'hFFFF_FFFC, 32'h0000_0000, 4'h8, 0, 1'b1, 1'b1, 32'hCAFE_CAFE, 32'h0000_0000, 1'b1};

    // Reset state
    #1;
    check("rst_req_ready", {63'd0, req_ready}, 64'd0);
    check("rst_rsp_valid", {63'd0, rsp_valid}, 64'd0);
    check("rst_cyc", {63'd0, wbm_cyc_o}, 64'd0);
    check("rst_adr", {32'd0, wbm_adr_o}, 64'd0);
    repeat (2) @(posedge wb_clk_i);
    @(negedge wb_clk_i);
    wb_rst_i = 1'b0;
    tick();
    check("post_rst_req_ready", {63'd0, req_ready}, 64'd1);

    // Table-driven single transactions
    for (int i = 0; i < 6; i++) begin
      dat_man = vecs[i].sdat;
      issue(vecs[i].we, vecs[i].adr, vecs[i].dat, vecs[i].sel);
      for (int unsigned w = 0; w < vecs[i].waits; w++) begin
        tick();
        check("wait_cyc", {63'd0, wbm_cyc_o}, 64'd1);
        check("wait_adr", {32'd0, wbm_adr_o}, {32'd0, vecs[i].adr});
        check("wait_rsp_valid", {63'd0, rsp_valid}, 64'd0);
      end
      ack_man = vecs[i].ack;
      err_man = vecs[i].err;
      tick();
      ack_man = 1'b0;
      err_man = 1'b0;
      check("end_cyc", {63'd0, wbm_cyc_o}, 64'd0);
      check("end_stb", {63'd0, wbm_stb_o}, 64'd0);
      check("rsp_valid", {63'd0, rsp_valid}, 64'd1);
      check("rsp_dat", {32'd0, rsp_dat}, {32'd0, vecs[i].exp_dat});
      check("rsp_err", {63'd0, rsp_err}, {63'd0, vecs[i].exp_err});
      check("held_adr", {32'd0, wbm_adr_o}, {32'd0, vecs[i].adr});
      rsp_ready = 1'b1;
      tick();
      rsp_ready = 1'b0;
      check("consume_rsp_valid", {63'd0, rsp_valid}, 64'd0);
      check("consume_rsp_dat", {32'd0, rsp_dat}, 64'd0);
      check("consume_rsp_err", {63'd0, rsp_err}, 64'd0);
      check("consume_req_ready", {63'd0, req_ready}, 64'd1);
    end

    // Error with ack, backpressure, and a new request that must be ignored
    dat_man = 32'h9999_9999;
    issue(1'b0, 32'h3000_0010, 32'h0, 4'hF);
    ack_man = 1'b1;
    err_man = 1'b1;
    tick();
    ack_man = 1'b0;
    err_man = 1'b0;
    req_we = 1'b1; req_adr = 32'h3000_0020; req_dat = 32'h0101_0101; req_valid = 1'b1;
    for (int k = 0; k < 5; k++) begin
      check("bp_rsp_valid", {63'd0, rsp_valid}, 64'd1);
      check("bp_rsp_err", {63'd0, rsp_err}, 64'd1);
      check("bp_rsp_dat", {32'd0, rsp_dat}, 64'd0);
      check("bp_req_ready", {63'd0, req_ready}, 64'd0);
      check("bp_cyc", {63'd0, wbm_cyc_o}, 64'd0);
      check("bp_adr", {32'd0, wbm_adr_o}, 64'h3000_0010);
      tick();
    end
    req_valid = 1'b0;
    rsp_ready = 1'b1;
    tick();
    rsp_ready = 1'b0;
    check("bp_consume_valid", {63'd0, rsp_valid}, 64'd0);
    check("bp_consume_ready", {63'd0, req_ready}, 64'd1);
    check("bp_no_cycle", {63'd0, wbm_cyc_o}, 64'd0);

    // Asynchronous reset in the middle of a bus cycle
    issue(1'b0, 32'h3000_0040, 32'h0, 4'hF);
    #2;
    wb_rst_i = 1'b1;
    #1;
    check("arst_cyc", {63'd0, wbm_cyc_o}, 64'd0);
    check("arst_stb", {63'd0, wbm_stb_o}, 64'd0);
    @(negedge wb_clk_i);
    wb_rst_i = 1'b0;
    ack_man  = 1'b1;
    tick();
    ack_man  = 1'b0;
    check("arst_req_ready", {63'd0, req_ready}, 64'd1);
    check("arst_rsp_valid", {63'd0, rsp_valid}, 64'd0);
    tick();
    check("arst_late_ack_rsp", {63'd0, rsp_valid}, 64'd0);
    check("arst_late_ack_cyc", {63'd0, wbm_cyc_o}, 64'd0);

    // Silent slave
    issue(1'b0, 32'h3000_0080, 32'h0, 4'hF);
`ifdef WB_INIT_TIMEOUT_EN
    begin
      int high_n;
      high_n = 1;
      for (int k = 0; k < 20; k++) begin
        tick();
        if (!wbm_cyc_o) break;
        high_n++;
      end
      check("timeout_cyc_clocks", 64'(high_n), 64'd8);
      check("timeout_rsp_valid", {63'd0, rsp_valid}, 64'd1);
      check("timeout_rsp_err", {63'd0, rsp_err}, 64'd1);
      check("timeout_rsp_dat", {32'd0, rsp_dat}, 64'd0);
      rsp_ready = 1'b1;
      tick();
      rsp_ready = 1'b0;
      check("timeout_consume", {63'd0, req_ready}, 64'd1);
    end
`else
    repeat (1000) tick();
    check("no_timeout_cyc", {63'd0, wbm_cyc_o}, 64'd1);
    check("no_timeout_rsp", {63'd0, rsp_valid}, 64'd0);
    wb_rst_i = 1'b1;
    @(negedge wb_clk_i);
    wb_rst_i = 1'b0;
    tick();
    check("recover_req_ready", {63'd0, req_ready}, 64'd1);
`endif

    // Back-to-back alternating reads and writes against the zero-wait model
    auto_mode = 1'b1;
    mon_en    = 1'b1;
    rsp_ready = 1'b1;
    req_sel   = 4'hF;
    for (int k = 0; k < 16; k++) begin
      int budget;
      req_we    = k[0];
      req_adr   = 32'h1000_0000 + 32'(4 * k);
      req_dat   = 32'hBEEF_0000 + 32'(k);
      req_valid = 1'b1;
      budget    = 10;
      while (!req_ready && budget > 0) begin
        tick();
        budget--;
      end
      if (budget == 0) check("b2b_ready_timeout", 64'(k), 64'hFFFF);
      tick();
    end
    req_valid = 1'b0;
    repeat (6) tick();
    mon_en = 1'b0;

    check("b2b_rsp_count", 64'(q_dat.size()), 64'd16);
    for (int k = 0; k < 16 && k < q_dat.size(); k++) begin
      check("b2b_rsp_dat", {32'd0, q_dat[k]}, k[0] ? 64'd0 : 64'(32'hC0DE_0000 + 32'(k)));
      check("b2b_rsp_err", {63'd0, q_err[k]}, 64'd0);
      if (k > 0) check("b2b_spacing", 64'(q_cyc[k] - q_cyc[k-1]), 64'd3);
      if (k[0]) check("b2b_write_data", {32'd0, wlog[k]}, 64'(32'hBEEF_0000 + 32'(k)));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
